// File: rtl/fifo_sync_flags.sv
// Single-clock FIFO storing all 2^ADDR_W entries, with occupancy level,
// programmable almost flags, sticky error flags, synchronous flush and rd_valid.
module fifo_sync_flags #(
  parameter int WIDTH     = 8,
  parameter int ADDR_W    = 9,
  parameter int AE_THRESH = 2,
  parameter int AF_THRESH = (1 << ADDR_W) - 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              clr_err,
  input  logic [WIDTH-1:0]  wrdata,
  input  logic              wr_en,
  input  logic              rd_en,
  output logic [WIDTH-1:0]  rddata,
  output logic              rd_valid,
  output logic              empty,
  output logic              full,
  output logic              almost_empty,
  output logic              almost_full,
  output logic [ADDR_W:0]   level,
  output logic              overflow,
  output logic              underflow
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] AE_LVL = (ADDR_W + 1)'(AE_THRESH);
  localparam logic [ADDR_W:0] AF_LVL = (ADDR_W + 1)'(AF_THRESH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [ADDR_W:0]  wptr;
  logic [ADDR_W:0]  rptr;
  logic             do_write;
  logic             do_read;
  logic             wr_err;
  logic             rd_err;

  // The extra wrap bit lets the full DEPTH be used: equal low bits with
  // differing MSBs means full, fully equal pointers means empty.
  assign level        = wptr - rptr;
  assign empty        = (wptr == rptr);
  assign full         = (wptr[ADDR_W-1:0] == rptr[ADDR_W-1:0]) &&
                        (wptr[ADDR_W] != rptr[ADDR_W]);
  assign almost_empty = (level <= AE_LVL);
  assign almost_full  = (level >= AF_LVL);

  // A flush cycle swallows both requests, so they can neither move data nor flag errors.
  assign do_write = wr_en & ~full  & ~flush;
  assign do_read  = rd_en & ~empty & ~flush;
  assign wr_err   = wr_en & full   & ~flush;
  assign rd_err   = rd_en & empty  & ~flush;

  always_ff @(posedge clk) begin
    if (do_write) begin
      mem[wptr[ADDR_W-1:0]] <= wrdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr     <= '0;
      rptr     <= '0;
      rddata   <= '0;
      rd_valid <= 1'b0;
    end else if (flush) begin
      wptr     <= '0;
      rptr     <= '0;
      rd_valid <= 1'b0;
    end else begin
      if (do_write) begin
        wptr <= wptr + 1'b1;
      end
      if (do_read) begin
        rptr   <= rptr + 1'b1;
        rddata <= mem[rptr[ADDR_W-1:0]];
      end
      rd_valid <= do_read;
    end
  end

  // A new error in the same cycle as clr_err wins over the clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_err) begin
        overflow <= 1'b1;
      end else if (clr_err) begin
        overflow <= 1'b0;
      end
      if (rd_err) begin
        underflow <= 1'b1;
      end else if (clr_err) begin
        underflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fifo_sync_flags.sv
// Bench for fifo_sync_flags: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then biased random traffic.
module tb_fifo_sync_flags;

  localparam int WIDTH  = 8;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 16;
  localparam int AE_T   = 2;
  localparam int AF_T   = 14;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              flush = 1'b0;
  logic              clr_err = 1'b0;
  logic [WIDTH-1:0]  wrdata = '0;
  logic              wr_en = 1'b0;
  logic              rd_en = 1'b0;
  logic [WIDTH-1:0]  rddata;
  logic              rd_valid;
  logic              empty;
  logic              full;
  logic              almost_empty;
  logic              almost_full;
  logic [ADDR_W:0]   level;
  logic              overflow;
  logic              underflow;

  int checks = 0;
  int failures = 0;
  bit check_en = 1'b0;

  fifo_sync_flags #(
    .WIDTH(WIDTH), .ADDR_W(ADDR_W), .AE_THRESH(AE_T), .AF_THRESH(AF_T)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .clr_err(clr_err),
    .wrdata(wrdata), .wr_en(wr_en), .rd_en(rd_en),
    .rddata(rddata), .rd_valid(rd_valid), .empty(empty), .full(full),
    .almost_empty(almost_empty), .almost_full(almost_full), .level(level),
    .overflow(overflow), .underflow(underflow)
  );

  // clock / reset
  always #5 clk = ~clk;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // reference model: the FIFO contents as a plain queue
  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] m_rddata = '0;
  bit               m_rd_valid = 1'b0;
  bit               m_ovf = 1'b0;
  bit               m_unf = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      m_rddata   = '0;
      m_rd_valid = 1'b0;
      m_ovf      = 1'b0;
      m_unf      = 1'b0;
    end else if (flush) begin
      exp_q.delete();
      m_rd_valid = 1'b0;
      if (clr_err) begin
        m_ovf = 1'b0;
        m_unf = 1'b0;
      end
    end else begin
      bit can_w, can_r;
      can_w = (exp_q.size() < DEPTH);
      can_r = (exp_q.size() > 0);
      if (clr_err) begin
        m_ovf = 1'b0;
        m_unf = 1'b0;
      end
      if (wr_en && !can_w) m_ovf = 1'b1;
      if (rd_en && !can_r) m_unf = 1'b1;
      if (rd_en && can_r) begin
        m_rddata   = exp_q.pop_front();
        m_rd_valid = 1'b1;
      end else begin
        m_rd_valid = 1'b0;
      end
      if (wr_en && can_w) exp_q.push_back(wrdata);
    end
  end

  // compare process: outputs are stable at the falling edge
  always @(negedge clk) begin
    if (check_en) begin
      int n;
      n = exp_q.size();
      chk("level", 32'(level), 32'(n));
      chk("empty", 32'(empty), 32'(n == 0));
      chk("full", 32'(full), 32'(n == DEPTH));
      chk("almost_empty", 32'(almost_empty), 32'(n <= AE_T));
      chk("almost_full", 32'(almost_full), 32'(n >= AF_T));
      chk("rd_valid", 32'(rd_valid), 32'(m_rd_valid));
      chk("rddata", 32'(rddata), 32'(m_rddata));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      chk("underflow", 32'(underflow), 32'(m_unf));
    end
  end

  // driver: inputs are applied just after a falling edge and held through the rising edge
  task automatic step(bit w, bit r, logic [WIDTH-1:0] d, bit f = 1'b0, bit c = 1'b0);
    wr_en   = w;
    rd_en   = r;
    wrdata  = d;
    flush   = f;
    clr_err = c;
    @(negedge clk);
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    flush   = 1'b0;
    clr_err = 1'b0;
  endtask

  initial begin
    logic [7:0] next_w;
    logic [7:0] next_r;
    bit saw_55;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check_en = 1'b1;
    @(negedge clk);
    chk("reset_level", 32'(level), 32'd0);
    chk("reset_empty", 32'(empty), 32'd1);
    chk("reset_ae", 32'(almost_empty), 32'd1);
    chk("reset_rddata", 32'(rddata), 32'd0);

    // 1: fill to full, watch flag thresholds, then overflow
    for (int i = 0; i < 16; i++) begin
      step(1, 0, 8'(i));
      chk("t1_level", 32'(level), 32'(i + 1));
      if (i + 1 == 13) chk("t1_af_low_13", 32'(almost_full), 32'd0);
      if (i + 1 == 14) chk("t1_af_rise_14", 32'(almost_full), 32'd1);
      if (i + 1 == 2)  chk("t1_ae_high_2", 32'(almost_empty), 32'd1);
      if (i + 1 == 3)  chk("t1_ae_fall_3", 32'(almost_empty), 32'd0);
    end
    chk("t1_full", 32'(full), 32'd1);
    step(1, 0, 8'hAA);
    chk("t1_overflow", 32'(overflow), 32'd1);
    chk("t1_level_held", 32'(level), 32'd16);

    // 2: drain in order, then underflow
    for (int i = 0; i < 16; i++) begin
      step(0, 1, '0);
      chk("t2_rddata", 32'(rddata), 32'(i));
      chk("t2_rd_valid", 32'(rd_valid), 32'd1);
    end
    chk("t2_empty", 32'(empty), 32'd1);
    step(0, 1, '0);
    chk("t2_underflow", 32'(underflow), 32'd1);
    chk("t2_rd_valid_low", 32'(rd_valid), 32'd0);
    step(0, 0, '0, 0, 1);
    chk("t2_clr_ovf", 32'(overflow), 32'd0);
    chk("t2_clr_unf", 32'(underflow), 32'd0);

    // 3: steady level 5 across pointer wrap
    next_w = 8'd100;
    next_r = 8'd100;
    for (int i = 0; i < 5; i++) begin
      step(1, 0, next_w);
      next_w++;
    end
    for (int i = 0; i < 40; i++) begin
      step(1, 1, next_w);
      next_w++;
      chk("t3_level", 32'(level), 32'd5);
      chk("t3_rddata", 32'(rddata), 32'(next_r));
      next_r++;
    end
    chk("t3_no_ovf", 32'(overflow), 32'd0);
    chk("t3_no_unf", 32'(underflow), 32'd0);

    // 4: simultaneous read/write while full
    for (int i = 0; i < 11; i++) begin
      step(1, 0, next_w);
      next_w++;
    end
    chk("t4_full", 32'(full), 32'd1);
    step(1, 1, 8'h55);
    chk("t4_oldest", 32'(rddata), 32'd140);
    chk("t4_level", 32'(level), 32'd15);
    chk("t4_overflow", 32'(overflow), 32'd1);
    saw_55 = 1'b0;
    for (int i = 0; i < 15; i++) begin
      step(0, 1, '0);
      if (rddata == 8'h55) saw_55 = 1'b1;
    end
    chk("t4_55_never_read", 32'(saw_55), 32'd0);

    // 5: flush at level 9 with both requests, then clear errors
    step(0, 1, '0);
    for (int i = 0; i < 9; i++) step(1, 0, 8'(8'h20 + i));
    chk("t5_level9", 32'(level), 32'd9);
    step(1, 1, 8'h77, 1);
    chk("t5_level0", 32'(level), 32'd0);
    chk("t5_empty", 32'(empty), 32'd1);
    chk("t5_rd_valid", 32'(rd_valid), 32'd0);
    chk("t5_ovf_kept", 32'(overflow), 32'd1);
    chk("t5_unf_kept", 32'(underflow), 32'd1);
    step(0, 0, '0, 0, 1);
    chk("t5_ovf_clr", 32'(overflow), 32'd0);
    chk("t5_unf_clr", 32'(underflow), 32'd0);

    // 6: asynchronous reset between edges
    for (int i = 0; i < 7; i++) step(1, 0, 8'(8'h40 + i));
    step(0, 1, '0);
    step(1, 0, 8'h50);
    step(1, 0, 8'h51);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_level", 32'(level), 32'd0);
    chk("t6_empty", 32'(empty), 32'd1);
    chk("t6_rd_valid", 32'(rd_valid), 32'd0);
    chk("t6_rddata", 32'(rddata), 32'd0);
    chk("t6_ae", 32'(almost_empty), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 0, 8'h3C);
    step(0, 1, '0);
    chk("t6_readback", 32'(rddata), 32'h3C);
    chk("t6_readback_valid", 32'(rd_valid), 32'd1);

    // random traffic in phases biased toward filling, draining, or balance
    for (int p = 0; p < 15; p++) begin
      int wp, rp;
      case (p % 3)
        0: begin wp = 80; rp = 25; end
        1: begin wp = 25; rp = 80; end
        default: begin wp = 60; rp = 60; end
      endcase
      for (int i = 0; i < 150; i++) begin
        step($urandom_range(99) < wp, $urandom_range(99) < rp, 8'($urandom),
             $urandom_range(199) == 0, $urandom_range(39) == 0);
      end
    end

    check_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
